// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide reservation station.
// Slot field widths follow RS_TAG_W/RS_DATA_W. The muldiv_rs TAG_W/DATA_W
// parameters default to these values and must be kept equal to them.
package muldiv_pkg;

  localparam logic [3:0] CTRL_MUL = 4'b0010;
  localparam logic [3:0] CTRL_DIV = 4'b0011;

  localparam int RS_TAG_W  = 5;
  localparam int RS_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_WB    = 2'd2,
    ST_DRAIN = 2'd3
  } rs_state_e;

  typedef struct packed {
    logic                 valid;
    logic [3:0]           ctrl;
    logic [RS_TAG_W-1:0]  rob;
    logic                 j_rdy;
    logic [RS_DATA_W-1:0] vj;
    logic [RS_TAG_W-1:0]  qj;
    logic                 k_rdy;
    logic [RS_DATA_W-1:0] vk;
    logic [RS_TAG_W-1:0]  qk;
  } rs_slot_t;

endpackage

// File: rtl/muldiv_rs_entry.sv
// One reservation-station slot: holds a micro-op and captures pending
// operands from the CDB broadcast.
module muldiv_rs_entry
  import muldiv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 wr_en,
  input  rs_slot_t             wr_slot,
  input  logic                 iss_clr,
  input  logic                 cdb_valid,
  input  logic [RS_TAG_W-1:0]  cdb_rob,
  input  logic [RS_DATA_W-1:0] cdb_value,
  output rs_slot_t             slot_o,
  output logic                 ready_o
);

  rs_slot_t slot_q, slot_d;

  // Next slot contents: snoop, free on issue, write on alloc; flush dominates.
  always_comb begin
    slot_d = slot_q;
    if (slot_q.valid && cdb_valid) begin
      if (!slot_q.j_rdy && (slot_q.qj == cdb_rob)) begin
        slot_d.j_rdy = 1'b1;
        slot_d.vj    = cdb_value;
      end
      if (!slot_q.k_rdy && (slot_q.qk == cdb_rob)) begin
        slot_d.k_rdy = 1'b1;
        slot_d.vk    = cdb_value;
      end
    end
    if (iss_clr) slot_d.valid = 1'b0;
    if (wr_en)   slot_d = wr_slot;
    if (clr)     slot_d.valid = 1'b0;
  end

  // Slot register.
  always_ff @(posedge clk) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

  assign slot_o  = slot_q;
  assign ready_o = slot_q.valid && slot_q.j_rdy && slot_q.k_rdy;

endmodule

// File: rtl/muldiv_rs.sv
// Reservation station and issue controller for the shared mul/div unit.
// Optional feature: MULDIV_RS_CDB_BYPASS_EN lets an allocating op pick up a
// same-cycle CDB broadcast; without it allocation stalls while cdb_valid=1.
module muldiv_rs
  import muldiv_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = RS_TAG_W,
  parameter int DATA_W  = RS_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [3:0]        alloc_ctrl,
  input  logic [TAG_W-1:0]  alloc_rob,
  input  logic              alloc_j_rdy,
  input  logic              alloc_k_rdy,
  input  logic [DATA_W-1:0] alloc_vj,
  input  logic [DATA_W-1:0] alloc_vk,
  input  logic [TAG_W-1:0]  alloc_qj,
  input  logic [TAG_W-1:0]  alloc_qk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_rob,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              eu_start,
  output logic [DATA_W-1:0] eu_x,
  output logic [DATA_W-1:0] eu_y,
  output logic [3:0]        eu_ctrl,
  output logic [TAG_W-1:0]  eu_save_no,
  output logic [TAG_W-1:0]  eu_rob,
  input  logic              eu_done,
  input  logic [TAG_W-1:0]  eu_save_no_in,
  input  logic [TAG_W-1:0]  eu_rob_in,
  input  logic [DATA_W-1:0] eu_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [TAG_W-1:0]  res_rob,
  output logic [DATA_W-1:0] res_value
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  rs_state_e state_q, state_d;

  rs_slot_t           slots [ENTRIES];
  rs_slot_t           alloc_slot;
  logic [ENTRIES-1:0] rdy_vec, free_vec, wr_vec, iss_vec;
  logic [IDX_W-1:0]   alloc_idx, sel_idx, last_q, last_d;
  logic               alloc_any, sel_any, alloc_fire, issue_fire;

  logic              eu_start_q, eu_start_d;
  logic [DATA_W-1:0] eu_x_q, eu_x_d, eu_y_q, eu_y_d;
  logic [3:0]        eu_ctrl_q, eu_ctrl_d;
  logic [TAG_W-1:0]  eu_save_no_q, eu_save_no_d, eu_rob_q, eu_rob_d;
  logic              res_valid_q, res_valid_d;
  logic [TAG_W-1:0]  res_rob_q, res_rob_d;
  logic [DATA_W-1:0] res_value_q, res_value_d;

  // The echoed slot number is only a consistency aid for the unit.
  logic unused_echo;
  assign unused_echo = ^eu_save_no_in;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_slot
    assign wr_vec[g]  = alloc_fire && (alloc_idx == IDX_W'(g));
    assign iss_vec[g] = issue_fire && (sel_idx == IDX_W'(g));
    assign free_vec[g] = !slots[g].valid;

    muldiv_rs_entry u_entry (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .wr_en     (wr_vec[g]),
      .wr_slot   (alloc_slot),
      .iss_clr   (iss_vec[g]),
      .cdb_valid (cdb_valid),
      .cdb_rob   (cdb_rob),
      .cdb_value (cdb_value),
      .slot_o    (slots[g]),
      .ready_o   (rdy_vec[g])
    );
  end

  // Lowest-index free slot for allocation.
  always_comb begin
    alloc_any = 1'b0;
    alloc_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        alloc_any = 1'b1;
        alloc_idx = IDX_W'(i);
      end
    end
  end

  // Round-robin pick: first ready slot after the one issued last.
  always_comb begin
    int idx;
    idx     = 0;
    sel_any = 1'b0;
    sel_idx = '0;
    for (int off = ENTRIES; off >= 1; off--) begin
      idx = (int'(last_q) + off) % ENTRIES;
      if (rdy_vec[idx]) begin
        sel_any = 1'b1;
        sel_idx = IDX_W'(idx);
      end
    end
  end

  // New slot image built from the dispatch bus.
  always_comb begin
    alloc_slot       = '0;
    alloc_slot.valid = 1'b1;
    alloc_slot.ctrl  = alloc_ctrl;
    alloc_slot.rob   = alloc_rob;
    alloc_slot.j_rdy = alloc_j_rdy;
    alloc_slot.vj    = alloc_vj;
    alloc_slot.qj    = alloc_qj;
    alloc_slot.k_rdy = alloc_k_rdy;
    alloc_slot.vk    = alloc_vk;
    alloc_slot.qk    = alloc_qk;
`ifdef MULDIV_RS_CDB_BYPASS_EN
    if (cdb_valid && !alloc_j_rdy && (alloc_qj == cdb_rob)) begin
      alloc_slot.j_rdy = 1'b1;
      alloc_slot.vj    = cdb_value;
    end
    if (cdb_valid && !alloc_k_rdy && (alloc_qk == cdb_rob)) begin
      alloc_slot.k_rdy = 1'b1;
      alloc_slot.vk    = cdb_value;
    end
`endif
  end

`ifdef MULDIV_RS_CDB_BYPASS_EN
  assign alloc_ready = alloc_any && (state_q != ST_DRAIN) && !flush;
`else
  assign alloc_ready = alloc_any && (state_q != ST_DRAIN) && !flush && !cdb_valid;
`endif
  assign alloc_fire = alloc_valid && alloc_ready;

  // Issue/complete/writeback sequencing and registered unit/result outputs.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    issue_fire   = 1'b0;
    eu_start_d   = eu_start_q;
    eu_x_d       = eu_x_q;
    eu_y_d       = eu_y_q;
    eu_ctrl_d    = eu_ctrl_q;
    eu_save_no_d = eu_save_no_q;
    eu_rob_d     = eu_rob_q;
    res_valid_d  = res_valid_q;
    res_rob_d    = res_rob_q;
    res_value_d  = res_value_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!flush && sel_any) begin
          issue_fire   = 1'b1;
          last_d       = sel_idx;
          state_d      = ST_BUSY;
          eu_start_d   = 1'b1;
          eu_x_d       = slots[sel_idx].vj;
          eu_y_d       = slots[sel_idx].vk;
          eu_ctrl_d    = slots[sel_idx].ctrl;
          eu_rob_d     = slots[sel_idx].rob;
          eu_save_no_d = TAG_W'(sel_idx);
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d    = ST_DRAIN;
          eu_start_d = 1'b0;
        end else if (eu_done) begin
          state_d     = ST_WB;
          eu_start_d  = 1'b0;
          res_valid_d = 1'b1;
          res_rob_d   = eu_rob_in;
          res_value_d = eu_result;
        end
      end
      ST_WB: begin
        if (flush || res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (eu_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_q       <= IDX_W'(ENTRIES - 1);
      eu_start_q   <= 1'b0;
      eu_x_q       <= '0;
      eu_y_q       <= '0;
      eu_ctrl_q    <= '0;
      eu_save_no_q <= '0;
      eu_rob_q     <= '0;
      res_valid_q  <= 1'b0;
      res_rob_q    <= '0;
      res_value_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      eu_start_q   <= eu_start_d;
      eu_x_q       <= eu_x_d;
      eu_y_q       <= eu_y_d;
      eu_ctrl_q    <= eu_ctrl_d;
      eu_save_no_q <= eu_save_no_d;
      eu_rob_q     <= eu_rob_d;
      res_valid_q  <= res_valid_d;
      res_rob_q    <= res_rob_d;
      res_value_q  <= res_value_d;
    end
  end

  assign eu_start   = eu_start_q;
  assign eu_x       = eu_x_q;
  assign eu_y       = eu_y_q;
  assign eu_ctrl    = eu_ctrl_q;
  assign eu_save_no = eu_save_no_q;
  assign eu_rob     = eu_rob_q;
  assign res_valid  = res_valid_q;
  assign res_rob    = res_rob_q;
  assign res_value  = res_value_q;

endmodule

// File: doc/muldiv_rs.md
# muldiv_rs

Reservation station and issue controller for the shared multiply/divide execution unit. Holds up to ENTRIES decoded MUL/DIV micro-ops, captures pending operands by snooping the CDB, issues one ready op at a time to the unit, waits for its completion, and presents the result with its ROB tag to the CDB arbiter. Sits between rename/dispatch and the multiply/divide unit; it drives that unit's start/operand inputs and consumes its done/result outputs.

## Interface
- ENTRIES, 4, station slots (2..16)
- TAG_W, 5, ROB tag / slot-number width
- DATA_W, 32, operand/result width

- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous and active-high
- flush  in  1  discard all entries and any in-flight op
- alloc_valid / alloc_ready  in / out  1 / 1  dispatch handshake
- alloc_ctrl  in  4  op code (4'b0010 MUL, 4'b0011 DIV)
- alloc_rob  in  TAG_W  destination ROB tag
- alloc_j_rdy, alloc_k_rdy  in  1  operand A/B value valid
- alloc_vj, alloc_vk  in  DATA_W  operand values
- alloc_qj, alloc_qk  in  TAG_W  producer ROB tags when not ready
- cdb_valid, cdb_rob, cdb_value  in  1 / TAG_W / DATA_W  broadcast snoop
- eu_start  out  1  start level to unit (data_ready)
- eu_x, eu_y  out  DATA_W  operands
- eu_ctrl  out  4  op code
- eu_save_no, eu_rob  out  TAG_W  issuing slot, ROB tag
- eu_done  in  1  unit completion, active high
- eu_save_no_in, eu_rob_in  in  TAG_W  tags echoed by unit
- eu_result  in  DATA_W  unit result
- res_valid / res_ready  out / in  1 / 1  result handshake to CDB arbiter
- res_rob, res_value  out  TAG_W / DATA_W  result tag and value

## Operation
- Slot: valid, ctrl, rob, j_rdy, vj, qj, k_rdy, vk, qk. Allocation writes lowest-index free slot when alloc_valid && alloc_ready.
- Snoop: every valid slot with pending operand whose q == cdb_rob while cdb_valid captures cdb_value, sets rdy.
- Ready slot: valid && j_rdy && k_rdy. Selection is round-robin, starting at slot after last issued.
- FSM: IDLE -> BUSY (ready slot exists; slot freed, eu_* registered from it, eu_start=1); BUSY -> WB on eu_done=1 (capture eu_rob_in, eu_result into res_*; eu_start=0); WB -> IDLE on res_valid && res_ready.
- flush: clears all slots; IDLE/WB -> IDLE (res_valid dropped); BUSY -> DRAIN with eu_start=0; DRAIN -> IDLE on eu_done=1, result discarded. Allocation blocked in DRAIN.
- eu_save_no_in/eu_rob_in must equal issued values when eu_done=1; mismatch is a bench error, RTL uses eu_rob_in.
- alloc_ready = free slot exists && state != DRAIN && !flush (plus Configuration rule). Slot freed this cycle not reusable until next cycle.
- Unknown ctrl is passed through unchanged.

## Timing
- Reset: all slots invalid, state IDLE, eu_start=0, eu_* =0, res_valid=0, res_rob=0, res_value=0; alloc_ready=1 first cycle after rst low.
- Alloc with both operands ready at cycle N: slot valid N+1, eu_start=1 at N+2.
- eu_start held high throughout BUSY; low ≥1 cycle between ops (WB/IDLE guarantee this).
- eu_done at cycle M: res_valid=1 at M+1; res_* stable until accepted. Back-to-back throughput: next eu_start ≥2 cycles after res accept.
- Simultaneous alloc and snoop of same slot impossible (slot not valid yet); see Configuration.
- rst mid-op: unit shares rst; station returns to reset state next cycle, no DRAIN.
- flush and alloc same cycle: flush wins, no allocation.

## Configuration
- MULDIV_RS_CDB_BYPASS_EN defined: alloc operand not ready whose q == cdb_rob with cdb_valid in same cycle is stored ready with cdb_value.
- Undefined: alloc_ready forced 0 whenever cdb_valid=1, so no broadcast is missed.

## Structure
- Package muldiv_pkg: CTRL_MUL, CTRL_DIV constants; FSM state enum (IDLE, BUSY, WB, DRAIN); slot struct typedef.
- Sub-module muldiv_rs_entry: one slot, including snoop/capture logic; instantiated ENTRIES times.

## Test plan
- Alloc MUL rob=3, vj=7, vk=6 both ready -> eu_start at +2 cycles, eu_x=7, eu_y=6, eu_ctrl=0010; eu_done with result 42 -> res_valid next cycle, res_rob=3, res_value=42.
- Alloc DIV rob=5 with qj=9 pending; cdb_valid rob=9 value=100 two cycles later -> issues only after capture, eu_x=100.
- Fill 4 slots -> alloc_ready=0; one issue -> alloc_ready=1 next cycle; round-robin issue order 0,1,2,3.
- flush during BUSY -> eu_start=0, DRAIN; eu_done 10 cycles later -> no res_valid, state IDLE, all slots empty.
- res_ready held 0 for 5 cycles in WB -> res_* stable, no new eu_start.
- cdb_valid rob=4 coincident with alloc qj=4: with MULDIV_RS_CDB_BYPASS_EN operand captured; without, alloc_ready=0 that cycle.
